// File: rtl/rheed_crop_stream.sv
// Crops an OUT_ROWS x OUT_COLS window out of a beat-packed RHEED frame stream, one pixel per cycle.
// Optional CROP_SUM_EN adds crop_sum, the running sum of all pixels handed out in the current window.
module rheed_crop_stream #(
  parameter int IN_ROWS  = 512,
  parameter int IN_COLS  = 512,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int PIX_W    = 8,
  parameter int IN_PPB   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  output logic                        crop_err,
  input  logic [$clog2(IN_COLS)-1:0]  crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]  crop_y0,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [IN_PPB*PIX_W-1:0]     s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [PIX_W-1:0]            m_axis_tdata,
`ifdef CROP_SUM_EN
  output logic [PIX_W+$clog2(OUT_ROWS*OUT_COLS)-1:0] crop_sum,
`endif
  output logic                        m_axis_tlast
);

  localparam int XW = $clog2(IN_COLS);
  localparam int YW = $clog2(IN_ROWS);
  localparam int KW = (IN_PPB > 1) ? $clog2(IN_PPB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SKIP} state_t;

  state_t                    state, state_nxt;
  logic [XW-1:0]             x0_q, col;
  logic [YW-1:0]             y0_q, row;
  logic [IN_PPB*PIX_W-1:0]   beat_p0;
  logic                      vld_p0;
  logic [KW-1:0]             idx_p0;
  logic                      oob, in_win, last_pix, last_frame, retire, accept, start;

  // Window bounds are evaluated one bit wider so x0+OUT_COLS cannot wrap.
  always_comb begin
    oob = (({1'b0, crop_x0} + (XW+1)'(OUT_COLS)) > (XW+1)'(IN_COLS)) ||
          (({1'b0, crop_y0} + (YW+1)'(OUT_ROWS)) > (YW+1)'(IN_ROWS));
    in_win = (col >= x0_q) && ({1'b0, col} < ({1'b0, x0_q} + (XW+1)'(OUT_COLS))) &&
             (row >= y0_q) && ({1'b0, row} < ({1'b0, y0_q} + (YW+1)'(OUT_ROWS)));
    last_pix = ({1'b0, col} == ({1'b0, x0_q} + (XW+1)'(OUT_COLS-1))) &&
               ({1'b0, row} == ({1'b0, y0_q} + (YW+1)'(OUT_ROWS-1)));
    last_frame = (col == XW'(IN_COLS-1)) && (row == YW'(IN_ROWS-1));
    start = (state == IDLE) && ap_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ap_start) state_nxt = oob ? SKIP : RUN;
      RUN,
      SKIP:     if (retire && last_frame) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ap_idle       = (state == IDLE);
    m_axis_tvalid = (state == RUN) && vld_p0 && in_win;
    m_axis_tdata  = m_axis_tvalid ? beat_p0[PIX_W-1:0] : '0;
    m_axis_tlast  = m_axis_tvalid && last_pix;
    retire        = vld_p0 && ((state == SKIP) ||
                               ((state == RUN) && (!in_win || m_axis_tready)));
    // A new beat may land in the same cycle the final buffered pixel leaves, except at frame end.
    s_axis_tready = ((state == RUN) || (state == SKIP)) &&
                    (!vld_p0 || (retire && (idx_p0 == KW'(IN_PPB-1)) && !last_frame));
    accept        = s_axis_tvalid && s_axis_tready;
  end

  // Stage p0: beat buffer control and frame position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      idx_p0   <= '0;
      col      <= '0;
      row      <= '0;
      ap_done  <= 1'b0;
      crop_err <= 1'b0;
    end else begin
      ap_done  <= retire && last_frame;
      crop_err <= start && oob;
      if (start) begin
        col <= '0;
        row <= '0;
      end else if (retire) begin
        if (col == XW'(IN_COLS-1)) begin
          col <= '0;
          row <= row + YW'(1);
        end else begin
          col <= col + XW'(1);
        end
      end
      if (accept) begin
        vld_p0 <= 1'b1;
        idx_p0 <= '0;
      end else if (retire) begin
        if ((idx_p0 == KW'(IN_PPB-1)) || last_frame) begin
          vld_p0 <= 1'b0;
          idx_p0 <= '0;
        end else begin
          idx_p0 <= idx_p0 + KW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      x0_q <= crop_x0;
      y0_q <= crop_y0;
    end
    if (accept)      beat_p0 <= s_axis_tdata;
    else if (retire) beat_p0 <= beat_p0 >> PIX_W;
  end

`ifdef CROP_SUM_EN
  localparam int SW = PIX_W + $clog2(OUT_ROWS*OUT_COLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               crop_sum <= '0;
    else if (start && !oob)                  crop_sum <= '0;
    else if (m_axis_tvalid && m_axis_tready) crop_sum <= crop_sum + SW'(m_axis_tdata);
  end
`endif

endmodule

// File: doc/rheed_crop_stream.md
RHEED_CROP_STREAM -- requirements
Module: rheed_crop_stream

Interface
REQ-001 SHALL have parameter IN_ROWS, default 512, input frame rows.
REQ-002 SHALL have parameter IN_COLS, default 512, input frame columns; must be a multiple of IN_PPB.
REQ-003 SHALL have parameter OUT_ROWS, default 48, crop window rows.
REQ-004 SHALL have parameter OUT_COLS, default 48, crop window columns.
REQ-005 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-006 SHALL have parameter IN_PPB, default 32, pixels per input beat.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port ap_start, input, 1, frame start request.
REQ-010 SHALL have port ap_idle, output, 1, high in IDLE.
REQ-011 SHALL have port ap_done, output, 1, one-cycle pulse at frame end.
REQ-012 SHALL have port crop_err, output, 1, one-cycle pulse when the latched window exceeds the frame.
REQ-013 SHALL have port crop_x0, input, clog2(IN_COLS), window left column.
REQ-014 SHALL have port crop_y0, input, clog2(IN_ROWS), window top row.
REQ-015 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tdata (input, IN_PPB*PIX_W), forming the input beat stream.
REQ-016 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, PIX_W) and m_axis_tlast (output, 1), forming the cropped pixel stream.

Function
REQ-017 SHALL implement the states IDLE, RUN and SKIP.
REQ-018 SHALL, in IDLE on ap_start, latch crop_x0/crop_y0, clear the row/column counters, and enter RUN, or enter SKIP if x0+OUT_COLS>IN_COLS or y0+OUT_ROWS>IN_ROWS.
REQ-019 SHALL pulse crop_err in the cycle after entry to SKIP.
REQ-020 SHALL ignore ap_start outside IDLE; later crop_x0/crop_y0 changes SHALL NOT affect the current frame.
REQ-021 SHALL assert s_axis_tready only in RUN or SKIP while the beat buffer is empty, or while the last buffered pixel is retiring that cycle (back-to-back beats allowed).
REQ-022 SHALL unpack an accepted beat in pixel order: pixel 0 = bits [PIX_W-1:0], pixel k = bits [(k+1)*PIX_W-1:k*PIX_W].
REQ-023 SHALL retire at most one pixel per cycle, advancing the column counter and wrapping to 0 with a row increment at IN_COLS-1.
REQ-024 SHALL, in RUN, retire a pixel outside the window (col in [x0,x0+OUT_COLS-1], row in [y0,y0+OUT_ROWS-1]) in one cycle with no output.
REQ-025 SHALL, in RUN, present a pixel inside the window on m_axis_tdata with m_axis_tvalid and retire it only on m_axis_tvalid&&m_axis_tready.
REQ-026 SHALL hold m_axis_tdata/tlast stable while tvalid&&!tready.
REQ-027 SHALL assert m_axis_tlast with the pixel at (y0+OUT_ROWS-1, x0+OUT_COLS-1).
REQ-028 SHALL, in SKIP, consume and discard all pixels with m_axis_tvalid held low.
REQ-029 SHALL, on retiring pixel (IN_ROWS-1, IN_COLS-1), pulse ap_done the next cycle and return to IDLE.
REQ-030 SHALL produce exactly OUT_ROWS*OUT_COLS output handshakes per RUN frame.
REQ-031 SHALL produce output latency of 1 cycle from beat acceptance to the first pixel being retirable.

Reset
REQ-032 SHALL, on reset (asynchronous, active-high), force state IDLE, ap_idle=1, ap_done=0, crop_err=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, all counters 0, and the buffer empty.
REQ-033 SHALL, on reset mid-frame, discard the partial beat and frame; the next frame SHALL start only on a new ap_start.

Configuration
REQ-034 SHALL, with CROP_SUM_EN defined, add output crop_sum (width PIX_W+clog2(OUT_ROWS*OUT_COLS)) that accumulates every handshaken output pixel, clears on entry to RUN, holds through ap_done until the next RUN, and resets to 0.
REQ-035 SHALL, without CROP_SUM_EN, omit the crop_sum port and accumulator logic entirely.

Verification
REQ-036 SHALL cover: IN 8x8, IN_PPB=4, OUT 2x2, x0=2, y0=3, pixel value = row*8+col -> outputs 26,27,34,35, tlast on 35, ap_done once.
REQ-037 SHALL cover: same frame with m_axis_tready toggling 1010 -> identical data order, no loss or duplication, tdata stable while stalled.
REQ-038 SHALL cover: x0=7, OUT_COLS=2 -> crop_err pulse, 16 beats accepted, zero output handshakes, ap_done, IDLE.
REQ-039 SHALL cover: ap_start and new crop_x0 asserted mid-RUN -> ignored, current output unchanged.
REQ-040 SHALL cover: reset asserted after 5 beats -> all outputs 0 immediately; following frame x0=0, y0=0 -> outputs 0,1,8,9.
REQ-041 SHALL cover (CROP_SUM_EN): first test frame -> crop_sum=122 after ap_done.
